// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// There is no valid/ready pair on this bus. Every input is a level that is
// sampled on each rising clock edge. Every output is a Moore decode of the
// registered state, so it is stable from shortly after that edge until the
// next one.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 4
);
  logic             start;
  logic             halt;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             branch_taken;
  logic             mem_busy;
  logic             clr_stats;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic [2:0]       state;
  logic [15:0]      stall_cnt;

  // The datapath or bench side drives the inputs and observes the controls.
  modport master (
    output start, halt, id_rs1, id_rs2, ex_rd, ex_mem_read,
           branch_taken, mem_busy, clr_stats,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze,
           state, stall_cnt
  );

  // The controller side.
  modport slave (
    input  start, halt, id_rs1, id_rs2, ex_rd, ex_mem_read,
           branch_taken, mem_busy, clr_stats,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze,
           state, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller. It detects load-use hazards, handles taken
// branches with a multi-cycle flush, and freezes the pipe while memory is busy.
// The state register is exported on bus.state so checkers can observe it.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STALL = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  // The counter holds the number of flush cycles still owed after the current one.
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [3:0]       flush_q;
  logic [3:0]       flush_d;
  logic [15:0]      cnt_q;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [REG_W-1:0] rd;
  logic             hazard;
  logic             counting;
  logic [4:0]       ctrl;

  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;
  assign rd  = bus.ex_rd;

  // Register 0 is hardwired to zero, so a load into it can never be a hazard.
  assign hazard = bus.ex_mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));

  // Cycles that are active but not in RUN count as stall cycles.
  assign counting = (state_q == S_STALL) || (state_q == S_FLUSH) || (state_q == S_WAIT);

  // Next state, with priority halt > mem_busy > branch > hazard.
  always_comb begin
    state_d = S_IDLE;
    flush_d = flush_q;
    if (bus.halt) begin
      state_d = S_IDLE;
      flush_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = bus.start ? S_RUN : S_IDLE;
        end
        // STALL and WAIT exits use the same rules as RUN, so a pending
        // branch or hazard is acted on at the edge where the pipe resumes.
        S_RUN, S_STALL, S_WAIT: begin
          if (bus.mem_busy) begin
            state_d = S_WAIT;
          end else if (bus.branch_taken) begin
            state_d = S_FLUSH;
            flush_d = FLUSH_RELOAD;
          end else if (hazard) begin
            state_d = S_STALL;
          end else begin
            state_d = S_RUN;
          end
        end
        S_FLUSH: begin
          if (bus.mem_busy) begin
            state_d = S_WAIT;
          end else if (bus.branch_taken) begin
            state_d = S_FLUSH;
            flush_d = FLUSH_RELOAD;
          end else if (flush_q == 4'd0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_FLUSH;
            flush_d = flush_q - 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          flush_d = '0;
        end
      endcase
    end
  end

  // State and flush-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Saturating stall statistic. A clear wins over an increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.clr_stats) begin
      cnt_q <= '0;
    end else if (counting && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Moore decode of {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze}.
  always_comb begin
    ctrl = 5'b00001;
    case (state_q)
      S_RUN:   ctrl = 5'b11000;
      S_STALL: ctrl = 5'b00010;
      S_FLUSH: ctrl = 5'b11110;
      S_WAIT:  ctrl = 5'b00001;
      default: ctrl = 5'b00001;
    endcase
  end

  assign bus.pc_en        = ctrl[4];
  assign bus.if_id_en     = ctrl[3];
  assign bus.if_id_flush  = ctrl[2];
  assign bus.id_ex_bubble = ctrl[1];
  assign bus.pipe_freeze  = ctrl[0];
  assign bus.state        = state_q;
  assign bus.stall_cnt    = cnt_q;

endmodule
